// File: rtl/ppu_render_sequencer.sv
// PPU dot/scanline raster timer and background fetch scheduler; strobes are zero-latency decodes.
// Optional PPU_ODD_FRAME_SKIP_EN drops the last pre-render dot on odd frames when rendering.
module ppu_render_sequencer #(
  parameter int unsigned DOTS_PER_LINE   = 341,
  parameter int unsigned LINES_PER_FRAME = 262,
  parameter int unsigned VBLANK_LINE     = 241,
  parameter int unsigned PRERENDER_LINE  = 261
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clkEn,
  input  logic       background_EN,
  input  logic       sprite_EN,
  input  logic       interrupt_EN,
  input  logic       verticalBlank,
  output logic [8:0] dot,
  output logic [8:0] scanline,
  output logic       oddFrame,
  output logic       setVerticalBlank,
  output logic       clearVerticalBlank,
  output logic       incrementX,
  output logic       incrementY,
  output logic       resetX,
  output logic       resetY,
  output logic       fetchValid,
  output logic [1:0] fetchKind,
  output logic       shiftReload,
  output logic       visible,
  output logic       nmi_n
);

  localparam logic [8:0] LAST_DOT  = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] SKIP_DOT  = 9'(DOTS_PER_LINE - 2);
  localparam logic [8:0] LAST_LINE = 9'(LINES_PER_FRAME - 1);
  localparam logic [8:0] VBL_LINE  = 9'(VBLANK_LINE);
  localparam logic [8:0] PRE_LINE  = 9'(PRERENDER_LINE);

  logic [8:0] dot_q, dot_d;
  logic [8:0] scanline_q, scanline_d;
  logic       odd_q, odd_d;
  logic       nmi_n_q, nmi_n_d;

  logic       render;
  logic       rline;
  logic       in_win;
  logic       skip;
  logic [2:0] phase;

  assign render = background_EN | sprite_EN;
  assign rline  = (scanline_q < 9'd240) || (scanline_q == PRE_LINE);

`ifdef PPU_ODD_FRAME_SKIP_EN
  assign skip = (scanline_q == PRE_LINE) && (dot_q == SKIP_DOT) && odd_q && render;
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    dot_d      = dot_q;
    scanline_d = scanline_q;
    odd_d      = odd_q;
    nmi_n_d    = !(verticalBlank && interrupt_EN);
    // The odd-frame skip behaves like an early end-of-frame wrap.
    if (skip || (dot_q == LAST_DOT)) begin
      dot_d = '0;
      if (skip || (scanline_q == LAST_LINE)) begin
        scanline_d = '0;
        odd_d      = ~odd_q;
      end else begin
        scanline_d = scanline_q + 9'd1;
      end
    end else begin
      dot_d = dot_q + 9'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dot_q      <= '0;
      scanline_q <= '0;
      odd_q      <= 1'b0;
      nmi_n_q    <= 1'b1;
    end else if (clkEn) begin
      dot_q      <= dot_d;
      scanline_q <= scanline_d;
      odd_q      <= odd_d;
      nmi_n_q    <= nmi_n_d;
    end
  end

  // Position within the 8-dot fetch group; dot 1 is phase 0.
  assign phase  = dot_q[2:0] - 3'd1;
  assign in_win = render && rline &&
                  (((dot_q >= 9'd1) && (dot_q <= 9'd256)) ||
                   ((dot_q >= 9'd321) && (dot_q <= 9'd336)));

  always_comb begin
    setVerticalBlank   = (scanline_q == VBL_LINE) && (dot_q == 9'd1);
    clearVerticalBlank = (scanline_q == PRE_LINE) && (dot_q == 9'd1);
    fetchValid         = in_win && phase[0];
    fetchKind          = 2'd0;
    if (in_win && phase[0]) begin
      fetchKind = phase[2:1];
    end
    incrementX  = in_win && (phase == 3'd7);
    incrementY  = rline && render && (dot_q == 9'd256);
    resetX      = rline && render && (dot_q == 9'd257);
    resetY      = (scanline_q == PRE_LINE) && render &&
                  (dot_q >= 9'd280) && (dot_q <= 9'd304);
    shiftReload = rline && render && (dot_q[2:0] == 3'd1) &&
                  (((dot_q >= 9'd9) && (dot_q <= 9'd257)) ||
                   (dot_q == 9'd329) || (dot_q == 9'd337));
    visible     = (scanline_q < 9'd240) && (dot_q >= 9'd1) && (dot_q <= 9'd256);
  end

  assign dot      = dot_q;
  assign scanline = scanline_q;
  assign oddFrame = odd_q;
  assign nmi_n    = nmi_n_q;

endmodule

// File: doc/ppu_render_sequencer.md
Name: ppu_render_sequencer

Overview:
- Dot/scanline timing generator and fetch scheduler for the PPU rendering datapath.
- Owns the 341×262 NTSC raster counters.
- Drives the VRAM-address register strobes (coarse-X/Y increment, horizontal/vertical copy-back) and the vblank set/clear pulses into the PPU register block.
- Tells the background fetch unit which memory fetch happens on each dot.

Parameters:
- DOTS_PER_LINE, 341, dots per scanline (counter wraps at DOTS_PER_LINE-1).
- LINES_PER_FRAME, 262, scanlines per frame.
- VBLANK_LINE, 241, scanline on which vblank is set.
- PRERENDER_LINE, 261, pre-render scanline (vblank clear, vertical copy-back).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- clkEn  in  1  PPU dot enable; all state advances only on clk edges with clkEn=1
- background_EN  in  1  background rendering enable from mask register
- sprite_EN  in  1  sprite rendering enable from mask register
- interrupt_EN  in  1  NMI enable from control register
- verticalBlank  in  1  vblank flag from register block
- dot  out  9  current dot, 0..340
- scanline  out  9  current scanline, 0..261
- oddFrame  out  1  frame parity
- setVerticalBlank  out  1  vblank set strobe
- clearVerticalBlank  out  1  vblank/overflow clear strobe
- incrementX  out  1  coarse-X increment strobe
- incrementY  out  1  fine/coarse-Y increment strobe
- resetX  out  1  horizontal copy t→v strobe
- resetY  out  1  vertical copy t→v strobe
- fetchValid  out  1  a fetch completes this dot
- fetchKind  out  2  0=nametable, 1=attribute, 2=pattern low, 3=pattern high
- shiftReload  out  1  reload background shifters
- visible  out  1  dot is a visible pixel (scanline<240, dot 1..256)
- nmi_n  out  1  active-low NMI to CPU

Behaviour:
- Reset (async, rst=1): dot=0, scanline=0, oddFrame=0, nmi_n=1. All strobes decode to 0 while rst is high.
- Counters (registered, advance on clkEn):
  - dot increments.
  - At dot=340: dot←0; scanline increments, wrapping 261→0.
  - At the 261→0 wrap, oddFrame toggles.
- render = background_EN | sprite_EN.
- rline = scanline<240 or scanline==PRERENDER_LINE.
- All strobes are combinational decodes of the current registered dot/scanline/render, zero latency. The register block samples them on the same clkEn edge that advances the counters. Each strobe is high for exactly one dot.
- setVerticalBlank: scanline==VBLANK_LINE and dot==1. Independent of render.
- clearVerticalBlank: scanline==PRERENDER_LINE and dot==1. Independent of render.
- Fetch window: dots 1..256 and 321..336 on rline with render=1. Let p=(dot-1) mod 8.
  - fetchValid=1 when p is odd.
  - fetchKind: p=1→0, 3→1, 5→2, 7→3.
- incrementX: in fetch window and p==7, i.e. dots 8,16,…,256,328,336.
- incrementY: rline, render, dot==256. Asserts in the same dot as incrementX; both must be honoured.
- resetX: rline, render, dot==257.
- resetY: scanline==PRERENDER_LINE, render, dot in 280..304 inclusive (25 consecutive strobes).
- shiftReload: rline, render, dot in {9,17,…,257,329,337}.
- render=0: all address/fetch strobes 0; counters keep running.
- Mid-line toggle of render takes effect on the next dot decode. No state is kept.
- nmi_n (registered): nmi_n←!(verticalBlank & interrupt_EN).
  - Setting interrupt_EN while verticalBlank=1 produces a new falling edge.
  - Clearing either input deasserts on the next clkEn edge.
- clkEn=0: all registers hold; strobes stay at their decoded values. The consumer ignores them without clkEn.

Optional Feature:
- Macro: PPU_ODD_FRAME_SKIP_EN.
- Defined: when scanline==PRERENDER_LINE, dot==339, oddFrame=1 and render=1, the next clkEn edge goes to dot=0, scanline=0 and toggles oddFrame. Dot 340 is skipped, so the frame is 89341 dots.
- Undefined: every frame is 89342 dots.

Test Plan:
- Assert rst mid-frame at scanline 100, dot 200 → outputs immediately 0/0/oddFrame 0, strobes 0, nmi_n=1. Counting resumes from 0 after release.
- render=0, free-run one frame → setVerticalBlank only at (241,1), clearVerticalBlank only at (261,1). No inc/reset/fetch strobes. Exactly 89342 clkEn cycles per frame.
- background_EN=1, scanline 10 → 34 incrementX, 1 incrementY at dot 256, resetX at 257, 34 shiftReload. fetchKind sequence 0,1,2,3 at dots 2,4,6,8.
- background_EN=1, pre-render line → resetY high on dots 280..304 (25 pulses), none on 279 or 305.
- verticalBlank=1 with interrupt_EN 0→1 → nmi_n falls one clkEn edge later. Dropping verticalBlank → nmi_n=1 next edge.
- With PPU_ODD_FRAME_SKIP_EN and render=1 → odd frame 89341 dots, even frame 89342. With render=0 both are 89342.
